// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the CPU datapath: fetch in T0-T2, then a
// per-instruction-class execute sequence in T3-T7 selected by ir[31:27].
module control_unit #(
  parameter logic [4:0] ALU_ADD = 5'b00011,
  parameter logic [4:0] ALU_INC = 5'b11111
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con,
  output logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
  output logic        HiSel, LoSel, ZHiSel, ZLoSel, PCSel, MDRSel, IPortSel, CSel,
  output logic        Gra, Grb, Grc, RIn, ROut, BAOut, ConIn,
  output logic        memread, memwrite, initMem,
  output logic [4:0]  ALUCode,
  output logic        run,
  output logic [4:0]  state_dbg
);

  typedef enum logic [4:0] {
    INIT = 5'd0, T0 = 5'd1, T1 = 5'd2, T2 = 5'd3, T3 = 5'd4,
    T4 = 5'd5, T5 = 5'd6, T6 = 5'd7, T7 = 5'd8, HALT = 5'd9
  } state_t;

  typedef struct packed {
    logic hiIn, loIn, zIn, pcIn, mdrIn, marIn, yIn, oPortIn, irIn;
    logic hiSel, loSel, zHiSel, zLoSel, pcSel, mdrSel, iPortSel, cSel;
    logic gra, grb, grc, rIn, rOut, baOut, conIn;
    logic memRead, memWrite, initMem, run;
    logic [4:0] aluCode;
  } ctrl_t;

  state_t state, nextState;
  logic   conLatch;
  ctrl_t  c;

  logic [4:0] op;
  logic       unusedIr;
  assign op       = ir[31:27];
  assign unusedIr = ^ir[26:0];

  logic isRType, isImm, isLd, isLdi, isSt, isMulDiv, isBr;
  logic isJr, isJal, isIn, isOut, isMfhi, isMflo, isHalt;
  assign isRType  = (op >= 5'b00011) && (op <= 5'b01011);
  assign isImm    = (op >= 5'b01100) && (op <= 5'b01110);
  assign isLd     = op == 5'b00000;
  assign isLdi    = op == 5'b00001;
  assign isSt     = op == 5'b00010;
  assign isMulDiv = (op == 5'b01111) || (op == 5'b10000);
  assign isBr     = op == 5'b10010;
  assign isJr     = op == 5'b10100;
  assign isJal    = op == 5'b10101;
  assign isIn     = op == 5'b10110;
  assign isOut    = op == 5'b10111;
  assign isMfhi   = op == 5'b11000;
  assign isMflo   = op == 5'b11001;
  assign isHalt   = op == 5'b11011;

  logic [4:0] immCode;
  always_comb begin
    unique case (op)
      5'b01101: immCode = 5'b00101;
      5'b01110: immCode = 5'b00110;
      default:  immCode = ALU_ADD;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= INIT;
      conLatch <= 1'b0;
    end else begin
      state <= nextState;
      // condition is sampled while the register under test drives the bus
      if (state == T3 && isBr) conLatch <= con;
    end
  end

  always_comb begin
    nextState = state;
    c         = '0;
    c.run     = 1'b1;
    unique case (state)
      INIT: begin c.initMem = 1'b1; nextState = T0; end
      T0: begin
        c.pcSel = 1'b1; c.marIn = 1'b1; c.zIn = 1'b1; c.aluCode = ALU_INC;
        nextState = T1;
      end
      T1: begin
        c.zLoSel = 1'b1; c.pcIn = 1'b1; c.memRead = 1'b1; c.mdrIn = 1'b1;
        nextState = T2;
      end
      T2: begin c.mdrSel = 1'b1; c.irIn = 1'b1; nextState = T3; end
      T3: begin
        nextState = T4;
        if (isRType || isImm) begin
          c.grb = 1'b1; c.rOut = 1'b1; c.yIn = 1'b1;
        end else if (isLd || isLdi || isSt) begin
          c.grb = 1'b1; c.baOut = 1'b1; c.yIn = 1'b1;
        end else if (isMulDiv) begin
          c.gra = 1'b1; c.rOut = 1'b1; c.yIn = 1'b1;
        end else if (isBr) begin
          c.gra = 1'b1; c.rOut = 1'b1; c.conIn = 1'b1;
        end else if (isJal) begin
          c.pcSel = 1'b1; c.grb = 1'b1; c.rIn = 1'b1;
        end else if (isHalt) begin
          nextState = HALT;
        end else begin
          // single-step ops; nop and unlisted opcodes fall through with no outputs
          nextState = T0;
          if (isJr)   begin c.gra = 1'b1; c.rOut = 1'b1; c.pcIn = 1'b1; end
          if (isIn)   begin c.iPortSel = 1'b1; c.gra = 1'b1; c.rIn = 1'b1; end
          if (isOut)  begin c.gra = 1'b1; c.rOut = 1'b1; c.oPortIn = 1'b1; end
          if (isMfhi) begin c.hiSel = 1'b1; c.gra = 1'b1; c.rIn = 1'b1; end
          if (isMflo) begin c.loSel = 1'b1; c.gra = 1'b1; c.rIn = 1'b1; end
        end
      end
      T4: begin
        nextState = T5;
        if (isRType) begin
          c.grc = 1'b1; c.rOut = 1'b1; c.zIn = 1'b1; c.aluCode = op;
        end else if (isImm) begin
          c.cSel = 1'b1; c.zIn = 1'b1; c.aluCode = immCode;
        end else if (isLd || isLdi || isSt) begin
          c.cSel = 1'b1; c.zIn = 1'b1; c.aluCode = ALU_ADD;
        end else if (isMulDiv) begin
          c.grb = 1'b1; c.rOut = 1'b1; c.zIn = 1'b1; c.aluCode = op;
        end else if (isBr) begin
          c.pcSel = 1'b1; c.yIn = 1'b1;
        end else begin
          nextState = T0;
          if (isJal) begin c.gra = 1'b1; c.rOut = 1'b1; c.pcIn = 1'b1; end
        end
      end
      T5: begin
        nextState = T0;
        if (isRType || isImm || isLdi) begin
          c.zLoSel = 1'b1; c.gra = 1'b1; c.rIn = 1'b1;
        end else if (isLd || isSt) begin
          c.zLoSel = 1'b1; c.marIn = 1'b1; nextState = T6;
        end else if (isMulDiv) begin
          c.zLoSel = 1'b1; c.loIn = 1'b1; nextState = T6;
        end else if (isBr) begin
          c.cSel = 1'b1; c.zIn = 1'b1; c.aluCode = ALU_ADD; nextState = T6;
        end
      end
      T6: begin
        nextState = T0;
        if (isLd) begin
          c.memRead = 1'b1; c.mdrIn = 1'b1; nextState = T7;
        end else if (isSt) begin
          c.gra = 1'b1; c.rOut = 1'b1; c.memWrite = 1'b1;
        end else if (isMulDiv) begin
          c.zHiSel = 1'b1; c.hiIn = 1'b1;
        end else if (isBr && conLatch) begin
          c.zLoSel = 1'b1; c.pcIn = 1'b1;
        end
      end
      T7: begin
        nextState = T0;
        if (isLd) begin c.mdrSel = 1'b1; c.gra = 1'b1; c.rIn = 1'b1; end
      end
      HALT: c.run = 1'b0;
      default: nextState = INIT;
    endcase
  end

  assign {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn} =
    {c.hiIn, c.loIn, c.zIn, c.pcIn, c.mdrIn, c.marIn, c.yIn, c.oPortIn, c.irIn};
  assign {HiSel, LoSel, ZHiSel, ZLoSel, PCSel, MDRSel, IPortSel, CSel} =
    {c.hiSel, c.loSel, c.zHiSel, c.zLoSel, c.pcSel, c.mdrSel, c.iPortSel, c.cSel};
  assign {Gra, Grb, Grc, RIn, ROut, BAOut, ConIn} =
    {c.gra, c.grb, c.grc, c.rIn, c.rOut, c.baOut, c.conIn};
  assign {memread, memwrite, initMem, run} = {c.memRead, c.memWrite, c.initMem, c.run};
  assign ALUCode   = c.aluCode;
  assign state_dbg = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven check of the control_unit sequencer, one row per
// clock cycle, plus hand sequences for asynchronous clear mid-cycle.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir    = '0;
  logic        con   = 1'b0;
  logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
  logic HiSel, LoSel, ZHiSel, ZLoSel, PCSel, MDRSel, IPortSel, CSel;
  logic Gra, Grb, Grc, RIn, ROut, BAOut, ConIn;
  logic memread, memwrite, initMem, run;
  logic [4:0] ALUCode, state_dbg;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con(con),
    .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn),
    .MARIn(MARIn), .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn),
    .HiSel(HiSel), .LoSel(LoSel), .ZHiSel(ZHiSel), .ZLoSel(ZLoSel),
    .PCSel(PCSel), .MDRSel(MDRSel), .IPortSel(IPortSel), .CSel(CSel),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut), .BAOut(BAOut),
    .ConIn(ConIn), .memread(memread), .memwrite(memwrite), .initMem(initMem),
    .ALUCode(ALUCode), .run(run), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  localparam logic [27:0] kHiIn = 28'h1 << 27, kLoIn = 28'h1 << 26, kZIn = 28'h1 << 25,
    kPCIn = 28'h1 << 24, kMDRIn = 28'h1 << 23, kMARIn = 28'h1 << 22, kYIn = 28'h1 << 21,
    kOPortIn = 28'h1 << 20, kIRIn = 28'h1 << 19, kHiSel = 28'h1 << 18, kLoSel = 28'h1 << 17,
    kZHiSel = 28'h1 << 16, kZLoSel = 28'h1 << 15, kPCSel = 28'h1 << 14, kMDRSel = 28'h1 << 13,
    kIPortSel = 28'h1 << 12, kCSel = 28'h1 << 11, kGra = 28'h1 << 10, kGrb = 28'h1 << 9,
    kGrc = 28'h1 << 8, kRIn = 28'h1 << 7, kROut = 28'h1 << 6, kBAOut = 28'h1 << 5,
    kConIn = 28'h1 << 4, kMemRead = 28'h1 << 3, kMemWrite = 28'h1 << 2,
    kInitMem = 28'h1 << 1, kRun = 28'h1;
  localparam logic [27:0] kInit = kInitMem | kRun;

  logic [27:0] act;
  assign act = {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
                HiSel, LoSel, ZHiSel, ZLoSel, PCSel, MDRSel, IPortSel, CSel,
                Gra, Grb, Grc, RIn, ROut, BAOut, ConIn,
                memread, memwrite, initMem, run};

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        con;
    logic [27:0] ctl;
    logic [4:0]  alu;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mk(input logic [4:0] op);
    return {op, 4'd1, 4'd2, 4'd3, 15'h0055};
  endfunction

  task automatic add(input string n, input logic [31:0] i, input logic c,
                     input logic [27:0] ctl, input logic [4:0] a);
    vec_t v;
    v.name = n; v.ir = i; v.con = c; v.ctl = ctl; v.alu = a;
    vecs.push_back(v);
  endtask

  task automatic fetch(input string n, input logic [31:0] i);
    add({n, " T0"}, i, 1'b0, kPCSel | kMARIn | kZIn | kRun, 5'b11111);
    add({n, " T1"}, i, 1'b0, kZLoSel | kPCIn | kMemRead | kMDRIn | kRun, 5'b0);
    add({n, " T2"}, i, 1'b0, kMDRSel | kIRIn | kRun, 5'b0);
  endtask

  task automatic check(input string n, input logic [27:0] ectl, input logic [4:0] ealu);
    total++;
    if (act !== ectl || ALUCode !== ealu) begin
      bad++;
      $display("FAIL %s: got ctl=%h alu=%b, want ctl=%h alu=%b", n, act, ALUCode, ectl, ealu);
    end
  endtask

  task automatic single(input string n, input logic [4:0] op, input logic [27:0] t3);
    fetch(n, mk(op));
    add({n, " T3"}, mk(op), 1'b0, t3 | kRun, 5'b0);
  endtask

  logic [31:0] irLd, irSt, irBr;

  initial begin
    irLd = 32'h00800055;
    irSt = 32'h10800055;
    irBr = mk(5'b10010);

    add("INIT", 32'h0, 1'b0, kInit, 5'b0);
    // add R1,R2,R3
    fetch("add", 32'h18918000);
    add("add T3", 32'h18918000, 1'b0, kGrb | kROut | kYIn | kRun, 5'b0);
    add("add T4", 32'h18918000, 1'b0, kGrc | kROut | kZIn | kRun, 5'b00011);
    add("add T5", 32'h18918000, 1'b0, kZLoSel | kGra | kRIn | kRun, 5'b0);
    // andi
    fetch("andi", mk(5'b01101));
    add("andi T3", mk(5'b01101), 1'b0, kGrb | kROut | kYIn | kRun, 5'b0);
    add("andi T4", mk(5'b01101), 1'b0, kCSel | kZIn | kRun, 5'b00101);
    add("andi T5", mk(5'b01101), 1'b0, kZLoSel | kGra | kRIn | kRun, 5'b0);
    // ld R1,0x55(R0)
    fetch("ld", irLd);
    add("ld T3", irLd, 1'b0, kGrb | kBAOut | kYIn | kRun, 5'b0);
    add("ld T4", irLd, 1'b0, kCSel | kZIn | kRun, 5'b00011);
    add("ld T5", irLd, 1'b0, kZLoSel | kMARIn | kRun, 5'b0);
    add("ld T6", irLd, 1'b0, kMemRead | kMDRIn | kRun, 5'b0);
    add("ld T7", irLd, 1'b0, kMDRSel | kGra | kRIn | kRun, 5'b0);
    // st
    fetch("st", irSt);
    add("st T3", irSt, 1'b0, kGrb | kBAOut | kYIn | kRun, 5'b0);
    add("st T4", irSt, 1'b0, kCSel | kZIn | kRun, 5'b00011);
    add("st T5", irSt, 1'b0, kZLoSel | kMARIn | kRun, 5'b0);
    add("st T6", irSt, 1'b0, kGra | kROut | kMemWrite | kRun, 5'b0);
    // ldi
    fetch("ldi", mk(5'b00001));
    add("ldi T3", mk(5'b00001), 1'b0, kGrb | kBAOut | kYIn | kRun, 5'b0);
    add("ldi T4", mk(5'b00001), 1'b0, kCSel | kZIn | kRun, 5'b00011);
    add("ldi T5", mk(5'b00001), 1'b0, kZLoSel | kGra | kRIn | kRun, 5'b0);
    // mul and div
    fetch("mul", mk(5'b01111));
    add("mul T3", mk(5'b01111), 1'b0, kGra | kROut | kYIn | kRun, 5'b0);
    add("mul T4", mk(5'b01111), 1'b0, kGrb | kROut | kZIn | kRun, 5'b01111);
    add("mul T5", mk(5'b01111), 1'b0, kZLoSel | kLoIn | kRun, 5'b0);
    add("mul T6", mk(5'b01111), 1'b0, kZHiSel | kHiIn | kRun, 5'b0);
    fetch("div", mk(5'b10000));
    add("div T3", mk(5'b10000), 1'b0, kGra | kROut | kYIn | kRun, 5'b0);
    add("div T4", mk(5'b10000), 1'b0, kGrb | kROut | kZIn | kRun, 5'b10000);
    add("div T5", mk(5'b10000), 1'b0, kZLoSel | kLoIn | kRun, 5'b0);
    add("div T6", mk(5'b10000), 1'b0, kZHiSel | kHiIn | kRun, 5'b0);
    // branch taken: con high only in T3, so T6 must rely on the latch
    fetch("brT", irBr);
    add("brT T3", irBr, 1'b1, kGra | kROut | kConIn | kRun, 5'b0);
    add("brT T4", irBr, 1'b0, kPCSel | kYIn | kRun, 5'b0);
    add("brT T5", irBr, 1'b0, kCSel | kZIn | kRun, 5'b00011);
    add("brT T6", irBr, 1'b0, kZLoSel | kPCIn | kRun, 5'b0);
    // branch not taken: con low in T3, high afterwards
    fetch("brN", irBr);
    add("brN T3", irBr, 1'b0, kGra | kROut | kConIn | kRun, 5'b0);
    add("brN T4", irBr, 1'b1, kPCSel | kYIn | kRun, 5'b0);
    add("brN T5", irBr, 1'b1, kCSel | kZIn | kRun, 5'b00011);
    add("brN T6", irBr, 1'b1, kRun, 5'b0);
    // jumps and single-step ops
    single("jr", 5'b10100, kGra | kROut | kPCIn);
    fetch("jal", mk(5'b10101));
    add("jal T3", mk(5'b10101), 1'b0, kPCSel | kGrb | kRIn | kRun, 5'b0);
    add("jal T4", mk(5'b10101), 1'b0, kGra | kROut | kPCIn | kRun, 5'b0);
    single("in", 5'b10110, kIPortSel | kGra | kRIn);
    single("out", 5'b10111, kGra | kROut | kOPortIn);
    single("mfhi", 5'b11000, kHiSel | kGra | kRIn);
    single("mflo", 5'b11001, kLoSel | kGra | kRIn);
    single("nop", 5'b11010, 28'h0);
    single("op10001", 5'b10001, 28'h0);
    single("op11110", 5'b11110, 28'h0);
    single("halt", 5'b11011, 28'h0);
    for (int k = 0; k < 10; k++) add($sformatf("HALT %0d", k), mk(5'b11011), 1'b1, 28'h0, 5'b0);

    // reset held for 3 cycles
    repeat (3) begin
      @(posedge clock);
      #1 check("reset hold", kInit, 5'b0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      if (i == 0) clear = 1'b1;
      ir  = vecs[i].ir;
      con = vecs[i].con;
      #1 check(vecs[i].name, vecs[i].ctl, vecs[i].alu);
    end

    // asynchronous clear out of HALT, away from any clock edge
    @(negedge clock);
    #2 clear = 1'b0;
    #1 check("clear in HALT", kInit, 5'b0);

    // release, run ld into T6, then clear mid-cycle
    @(negedge clock);
    clear = 1'b1;
    ir    = irLd;
    con   = 1'b0;
    #1 check("re-INIT", kInit, 5'b0);
    repeat (7) @(negedge clock);
    #1 check("ld2 T6", kMemRead | kMDRIn | kRun, 5'b0);
    #1 clear = 1'b0;
    #1 check("clear in ld T6", kInit, 5'b0);
    @(negedge clock);
    clear = 1'b1;
    #1 check("re-INIT 2", kInit, 5'b0);
    @(negedge clock);
    #1 check("re-T0", kPCSel | kMARIn | kZIn | kRun, 5'b11111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore-style sequencer that drives every control input of the CPU datapath: register enables, bus selects, Gra/Grb/Grc/RIn/ROut/BAOut, ConIn, memread/memwrite, ALUCode and initMem.
- Observes the datapath only through the instruction register value and the CON_FF output.
- Steps each instruction through fetch (T0–T2) and a class-specific execute sequence (T3–T7).
- Together with the datapath it forms the complete processor.

Parameters:
- ALU_ADD, 5'b00011, ALUCode used for effective-address and branch-target adds.
- ALU_INC, 5'b11111, ALUCode that makes Z = bus + 1 (PC increment).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset; asynchronous, active-low.
- ir  in  32  IR register value; opcode = ir[31:27].
- con  in  1  CON_FF output.
- HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn  out  1 each  register enables.
- HiSel, LoSel, ZHiSel, ZLoSel, PCSel, MDRSel, IPortSel, CSel  out  1 each  bus selects.
- Gra, Grb, Grc, RIn, ROut, BAOut, ConIn  out  1 each  register-field and condition controls.
- memread, memwrite, initMem  out  1 each  memory controls.
- ALUCode  out  5  ALU operation code.
- run  out  1  high while executing; low in HALT.
- state_dbg  out  5  current state encoding, for debug only.

Behaviour:
- Registers: the only sequential elements are the state register (states INIT, T0..T7, HALT) and a 1-bit latched copy of con.
- Output decode: all outputs are combinational from state and ir[31:27]. Any output not listed for a state is 0.
- Reset: clear=0 forces state INIT immediately, regardless of current state (including mid-instruction and HALT), and clears the con latch.
- Outputs in INIT: initMem=1, run=1, all others 0.
- After clear rises: INIT lasts exactly one clock, then T0.
- Fetch:
  - T0: PCSel, MARIn, ZIn, ALUCode=ALU_INC.
  - T1: ZLoSel, PCIn, memread, MDRIn.
  - T2: MDRSel, IRIn.
  - The opcode is decoded from T3 onward; ir is stable from T3 until the next T2.
- R-type (op 00011–01011):
  - T3: Grb, ROut, YIn.
  - T4: Grc, ROut, ZIn, ALUCode=op.
  - T5: ZLoSel, Gra, RIn. Then T0.
- Immediate (op 01100 addi / 01101 andi / 01110 ori):
  - T3: Grb, ROut, YIn.
  - T4: CSel, ZIn, ALUCode = 00011 / 00101 / 00110 respectively.
  - T5: ZLoSel, Gra, RIn. Then T0.
- ld (00000), ldi (00001), st (00010):
  - T3: Grb, BAOut, YIn.
  - T4: CSel, ZIn, ALUCode=ALU_ADD.
  - T5: ldi does ZLoSel, Gra, RIn, then T0. ld/st do ZLoSel, MARIn.
  - ld: T6 memread, MDRIn; T7 MDRSel, Gra, RIn; then T0.
  - st: T6 Gra, ROut, memwrite (exactly one cycle); then T0.
- mul (01111), div (10000):
  - T3: Gra, ROut, YIn.
  - T4: Grb, ROut, ZIn, ALUCode=op.
  - T5: ZLoSel, LoIn.
  - T6: ZHiSel, HiIn. Then T0.
- Conditional branch (10010):
  - T3: Gra, ROut, ConIn; con latch loads con at the end of T3.
  - T4: PCSel, YIn.
  - T5: CSel, ZIn, ALUCode=ALU_ADD.
  - T6: if latched con=1, ZLoSel, PCIn; else no outputs. Then T0.
- Jumps:
  - jr (10100): T3 Gra, ROut, PCIn.
  - jal (10101): T3 PCSel, Grb, RIn (link); T4 Gra, ROut, PCIn.
- Single-step ops, each T3 only:
  - in (10110): IPortSel, Gra, RIn.
  - out (10111): Gra, ROut, OPortIn.
  - mfhi (11000): HiSel, Gra, RIn.
  - mflo (11001): LoSel, Gra, RIn.
- nop (11010): T3 with no outputs, then T0.
- Unlisted opcodes: behave as nop.
- halt (11011): T3 goes to HALT. HALT holds with all outputs 0 and run=0; it exits only via clear.
- Invariants:
  - memread and memwrite are never both 1.
  - Exactly one bus source (a Sel signal, CSel or ROut) is active in any state that loads a register.
  - ALUCode is 0 in every state where ZIn=0.
- Cycle counts including fetch: R-type/immediate/ldi 6; ld 8; st 7; mul/div/branch 7; in/out/mf/jr/nop 4; jal 5.

Test Plan:
- Reset/INIT: hold clear=0 for 3 cycles, then release. Expect initMem=1 for exactly 1 cycle, then T0 with PCSel=MARIn=ZIn=1 and ALUCode=5'b11111; run=1.
- R-type: load ir=32'h18918000 (add R1,R2,R3) at T2. Expect T3 Grb/ROut/YIn, T4 Grc/ROut/ZIn with ALUCode=00011, T5 ZLoSel/Gra/RIn, T0 on cycle 7.
- ld then st: ir=32'h00800055 (ld R1,0x55(R0)). Expect BAOut=1 at T3, memread=1 at T1 and T6, RIn at T7. Then ir=32'h10800055 (st). Expect memwrite=1 only at T6, never together with memread.
- Branch: opcode 10010 with con=1 at T3, then repeat with con=0. Expect PCIn=1 at T6 only in the con=1 run; 7 cycles in both.
- mul: opcode 01111. Expect LoIn at T5 and HiIn at T6, ALUCode=01111 at T4, ZIn=0 outside T0/T4.
- halt and async reset: opcode 11011. Expect HALT with run=0 and outputs 0 for 10 cycles. Then pull clear low mid-cycle: state goes to INIT without waiting for a clock edge. Also assert clear during ld T6: memread drops immediately.
